// File: rtl/lsu_pkg.sv
// Shared funct3 encodings and FSM state type for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering, byte enables, load extension and legality checks (purely combinational).
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] bus_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic        mis;
    logic        sext;
    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        if (we_i) begin
            illegal_o = !(funct3_i inside {F3_B, F3_H, F3_W});
        end else begin
            illegal_o = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end

        shifted = bus_rdata_i >> {addr_lo_i, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = addr_lo_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        sext    = !funct3_i[2];

        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        mis     = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext & lane_b[7]}}, lane_b};
            end
            2'b01: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sext & lane_h[15]}}, lane_h};
                mis     = addr_lo_i[0];
            end
            2'b10: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = bus_rdata_i;
                mis     = |addr_lo_i;
            end
            default: ;
        endcase

        // An illegal funct3 is reported as a fault, never as misaligned.
        misaligned_o = mis & !illegal_o;
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: turns core memory requests into req/ack bus accesses and stalls
// the core until each access completes, faults or times out.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q;
    logic [15:0] cnt_q;
    logic [2:0]  f3_q;
    logic [1:0]  alo_q;
    logic        we_q;
    logic        fault_q;
    logic [31:0] rdata_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;

    logic        access;
    logic        in_idle;
    logic        a_we;
    logic [2:0]  a_f3;
    logic [1:0]  a_alo;
    logic [3:0]  a_be;
    logic [31:0] a_wdata;
    logic [31:0] a_rdata;
    logic        a_mis;
    logic        a_ill;
    logic        legal;

    // In IDLE the aligner sees the live request; afterwards it sees the latched one for extension.
    always_comb begin
        access  = mem_read | mem_write;
        in_idle = (state_q == IDLE);
        a_we    = in_idle ? mem_write : we_q;
        a_f3    = in_idle ? funct3 : f3_q;
        a_alo   = in_idle ? addr[1:0] : alo_q;
        legal   = in_idle & access & !a_ill & !a_mis;
    end

    lsu_align u_align (
        .we_i         (a_we),
        .funct3_i     (a_f3),
        .addr_lo_i    (a_alo),
        .wdata_i      (wdata),
        .bus_rdata_i  (bus_rdata),
        .be_o         (a_be),
        .wdata_o      (a_wdata),
        .rdata_o      (a_rdata),
        .misaligned_o (a_mis),
        .illegal_o    (a_ill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            f3_q        <= 3'b000;
            alo_q       <= 2'b00;
            we_q        <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= 32'h0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= 16'd0;
                    if (legal) begin
                        f3_q        <= funct3;
                        alo_q       <= addr[1:0];
                        we_q        <= mem_write;
                        bus_we_q    <= mem_write;
                        bus_addr_q  <= {addr[31:2], 2'b00};
                        bus_be_q    <= a_be;
                        bus_wdata_q <= mem_write ? a_wdata : 32'h0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        rdata_q <= (bus_err | we_q) ? 32'h0 : a_rdata;
                        fault_q <= bus_err;
                        state_q <= DONE;
                    end else if (cnt_q == TimeoutLast) begin
                        rdata_q <= 32'h0;
                        fault_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    cnt_q   <= 16'd0;
                    fault_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Combinational outputs are gated by reset so everything reads 0 while rst_n is low.
    always_comb begin
        stall      = rst_n & (legal | (state_q == REQ));
        misaligned = rst_n & in_idle & access & a_mis;
        fault      = rst_n & ((in_idle & access & a_ill) | ((state_q == DONE) & fault_q));
        rdata      = (state_q == DONE) ? rdata_q : 32'h0;
        bus_req    = (state_q == REQ);
        bus_we     = bus_we_q;
        bus_addr   = bus_addr_q;
        bus_be     = bus_be_q;
        bus_wdata  = bus_wdata_q;
    end

endmodule
